// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer: IDLE/FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT with ready-wait timeout.
// Strobes are decoded from the registered stage plus this cycle's ready inputs; STAGE_SEQ_PERF_EN adds instret/cycles counters.
module stage_sequencer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        resume,
    input  logic [6:0]  opcode,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic        dmem_re,
    output logic        dmem_we,
    output logic [2:0]  stage,
    output logic        halted,
    output logic        illegal,
    output logic        timeout,
    output logic [31:0] instret,
    output logic [31:0] cycles
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       is_load, is_store, is_branch, is_system, is_legal;
    logic       wait_ready, wait_expire;

    assign stage     = state;
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_system = (opcode == OP_SYSTEM);

    always_comb begin
        is_legal = 1'b0;
        case (opcode)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011: is_legal = 1'b1;
            default: is_legal = 1'b0;
        endcase
    end

    // The final wait cycle with ready still low becomes the timeout cycle and drives no strobes.
    assign wait_ready  = (state == S_FETCH) ? imem_ready : dmem_ready;
    assign wait_expire = !wait_ready && (wait_cnt == WAIT_LAST);

    always_comb begin
        ir_we   = (state == S_FETCH) && imem_ready;
        dmem_re = (state == S_MEMORY) && is_load  && !wait_expire;
        dmem_we = (state == S_MEMORY) && is_store && !wait_expire;
        rf_we   = (state == S_WRITEBACK);
        pc_we   = (state == S_WRITEBACK)
               || ((state == S_EXECUTE) && is_branch)
               || ((state == S_MEMORY) && is_store && dmem_ready);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state    <= S_FETCH;
                        wait_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        state <= S_DECODE;
                    end else if (wait_expire) begin
                        state   <= S_HALT;
                        halted  <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (!is_legal) begin
                        state   <= S_HALT;
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                    end else if (is_system) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    wait_cnt <= '0;
                    if (is_load || is_store) state <= S_MEMORY;
                    else if (is_branch)      state <= run ? S_FETCH : S_IDLE;
                    else                     state <= S_WRITEBACK;
                end
                S_MEMORY: begin
                    if (dmem_ready) begin
                        wait_cnt <= '0;
                        if (is_load) state <= S_WRITEBACK;
                        else         state <= run ? S_FETCH : S_IDLE;
                    end else if (wait_expire) begin
                        state   <= S_HALT;
                        halted  <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WRITEBACK: begin
                    wait_cnt <= '0;
                    state    <= run ? S_FETCH : S_IDLE;
                end
                S_HALT: begin
                    if (resume) begin
                        state   <= S_IDLE;
                        halted  <= 1'b0;
                        illegal <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef STAGE_SEQ_PERF_EN
    logic [31:0] instret_q, cycles_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_q <= '0;
            cycles_q  <= '0;
        end else begin
            if (pc_we) instret_q <= instret_q + 32'd1;
            if (state != S_IDLE && state != S_HALT) cycles_q <= cycles_q + 32'd1;
        end
    end

    assign instret = instret_q;
    assign cycles  = cycles_q;
`else
    assign instret = '0;
    assign cycles  = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized instruction-level bench: each instruction is expanded into its expected per-cycle trace, then replayed.
module tb_stage_sequencer;
    localparam int MW = 4;
    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                           MEM = 3'd4, WB = 3'd5, HALT = 3'd6;
    localparam logic [6:0] OP_R = 7'b0110011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                           OP_BR = 7'b1100011, OP_SYS = 7'b1110011;

    logic        clk = 1'b0;
    logic        rst, run, resume, imem_ready, dmem_ready;
    logic [6:0]  opcode;
    logic        ir_we, pc_we, rf_we, dmem_re, dmem_we, halted, illegal, timeout;
    logic [2:0]  stage;
    logic [31:0] instret, cycles;

    stage_sequencer #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .run(run), .resume(resume), .opcode(opcode),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .dmem_re(dmem_re), .dmem_we(dmem_we),
        .stage(stage), .halted(halted), .illegal(illegal), .timeout(timeout),
        .instret(instret), .cycles(cycles)
    );

    always #5 clk = ~clk;

    // strb = {ir_we, pc_we, rf_we, dmem_re, dmem_we}; flg = {halted, illegal, timeout}
    typedef struct {
        logic [2:0] stg;
        logic [4:0] strb;
        logic [2:0] flg;
        logic       run, res, imr, dmr;
        logic [6:0] op;
    } vec_t;

    vec_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          where = 0;          // 0: parked in IDLE, 1: next cycle is FETCH, 2: parked in HALT
    logic [2:0]  hflags = 3'b000;
    logic [31:0] cyc_m = 0, ins_m = 0;
    logic [6:0]  ops[10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        if (obs !== expv) begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    function automatic logic legal(input logic [6:0] op);
        foreach (ops[i]) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input logic [2:0] stg, input logic [4:0] strb, input logic [2:0] flg,
                        input logic r, input logic rs, input logic imr, input logic dmr,
                        input logic [6:0] op);
        vec_t v;
        v.stg = stg; v.strb = strb; v.flg = flg;
        v.run = r; v.res = rs; v.imr = imr; v.dmr = dmr; v.op = op;
        q.push_back(v);
    endtask

    // One instruction: fw/mw = cycles of ready low before ready; >= MW means it never arrives.
    task automatic step(input logic [6:0] op, input int fw, input int mw, input logic ra);
        int k;
        logic ld;
        if (where == 2) begin
            k = $urandom_range(0, 2);
            for (int i = 0; i < k; i++) push(HALT, 5'b0, hflags, rb(), 1'b0, rb(), rb(), rop());
            push(HALT, 5'b0, hflags, rb(), 1'b1, rb(), rb(), rop());
            where = 0;
        end
        if (where == 0) begin
            k = $urandom_range(0, 2);
            for (int i = 0; i < k; i++) push(IDLE, 5'b0, 3'b0, 1'b0, rb(), rb(), rb(), rop());
            push(IDLE, 5'b0, 3'b0, 1'b1, rb(), rb(), rb(), rop());
            where = 1;
        end
        for (int i = 0; i < fw && i < MW; i++) push(FETCH, 5'b0, 3'b0, rb(), rb(), 1'b0, rb(), rop());
        if (fw >= MW) begin hflags = 3'b101; where = 2; return; end
        push(FETCH, 5'b10000, 3'b0, rb(), rb(), 1'b1, rb(), rop());
        push(DECODE, 5'b0, 3'b0, ra, rb(), rb(), rb(), op);
        if (!legal(op)) begin hflags = 3'b110; where = 2; return; end
        if (op == OP_SYS) begin hflags = 3'b100; where = 2; return; end
        if (op == OP_BR) begin
            push(EXEC, 5'b01000, 3'b0, ra, rb(), rb(), rb(), op);
            where = ra ? 1 : 0;
            return;
        end
        push(EXEC, 5'b0, 3'b0, ra, rb(), rb(), rb(), op);
        if (op == OP_LOAD || op == OP_STORE) begin
            ld = (op == OP_LOAD);
            for (int i = 0; i < mw && i < MW; i++)
                push(MEM, (i == MW - 1) ? 5'b0 : (ld ? 5'b00010 : 5'b00001), 3'b0, ra, rb(), rb(), 1'b0, op);
            if (mw >= MW) begin hflags = 3'b101; where = 2; return; end
            if (!ld) begin
                push(MEM, 5'b01001, 3'b0, ra, rb(), rb(), 1'b1, op);
                where = ra ? 1 : 0;
                return;
            end
            push(MEM, 5'b00010, 3'b0, ra, rb(), rb(), 1'b1, op);
        end
        push(WB, 5'b01100, 3'b0, ra, rb(), rb(), rb(), op);
        where = ra ? 1 : 0;
    endtask

    task automatic play();
        logic [31:0] exp_ins, exp_cyc;
        foreach (q[i]) begin
            vec_t v;
            v = q[i];
            @(negedge clk);
            run = v.run; resume = v.res; imem_ready = v.imr; dmem_ready = v.dmr; opcode = v.op;
            #1;
            vectors++;
`ifdef STAGE_SEQ_PERF_EN
            exp_ins = ins_m; exp_cyc = cyc_m;
`else
            exp_ins = 32'd0; exp_cyc = 32'd0;
`endif
            chk("stage", 32'(stage), 32'(v.stg));
            chk("ir_we", 32'(ir_we), 32'(v.strb[4]));
            chk("pc_we", 32'(pc_we), 32'(v.strb[3]));
            chk("rf_we", 32'(rf_we), 32'(v.strb[2]));
            chk("dmem_re", 32'(dmem_re), 32'(v.strb[1]));
            chk("dmem_we", 32'(dmem_we), 32'(v.strb[0]));
            chk("halted", 32'(halted), 32'(v.flg[2]));
            chk("illegal", 32'(illegal), 32'(v.flg[1]));
            chk("timeout", 32'(timeout), 32'(v.flg[0]));
            chk("instret", instret, exp_ins);
            chk("cycles", cycles, exp_cyc);
            if (v.strb[3]) ins_m++;
            if (v.stg != IDLE && v.stg != HALT) cyc_m++;
        end
        q.delete();
    endtask

    task automatic check_reset(input string tag);
        vectors++;
        chk({tag, "_stage"}, 32'(stage), 32'(IDLE));
        chk({tag, "_strobes"}, 32'({ir_we, pc_we, rf_we, dmem_re, dmem_we}), 32'd0);
        chk({tag, "_flags"}, 32'({halted, illegal, timeout}), 32'd0);
        chk({tag, "_instret"}, instret, 32'd0);
        chk({tag, "_cycles"}, cycles, 32'd0);
        cyc_m = 0; ins_m = 0; where = 0;
    endtask

    initial begin
        int x, fw, mw;
        logic [6:0] op;
        rst = 1'b0; run = 1'b0; resume = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; opcode = '0;
        #1;
        check_reset("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Directed: R-type back to back, delayed load, store/branch, illegal, fetch and memory timeout edges
        step(OP_R, 0, 0, 1'b1);
        step(OP_R, 0, 0, 1'b1);
        step(OP_LOAD, 0, 3, 1'b1);
        step(OP_STORE, 0, 0, 1'b1);
        step(OP_BR, 0, 0, 1'b0);
        step(7'b0000000, 0, 0, 1'b1);
        step(OP_R, MW, 0, 1'b1);
        step(OP_R, MW - 1, 0, 1'b1);
        step(OP_LOAD, 0, MW, 1'b1);
        step(OP_STORE, 0, MW - 1, 1'b0);
        step(OP_SYS, 0, 0, 1'b1);
        play();

        for (int n = 0; n < 300; n++) begin
            x = $urandom_range(0, 12);
            op = (x < 10) ? ops[x] : ((x == 10) ? 7'b0000000 : rop());
            fw = ($urandom_range(0, 9) == 9) ? MW : $urandom_range(0, MW - 1);
            mw = ($urandom_range(0, 9) == 9) ? MW : $urandom_range(0, MW - 1);
            step(op, fw, mw, ($urandom_range(0, 3) != 0));
        end
        play();

        // Asynchronous reset from wherever the random run left the sequencer
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset("reset_any");
        run = 1'b0; resume = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Reset in the middle of a stalled store: dmem_we must drop with no clock edge
        push(IDLE, 5'b0, 3'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0);
        push(FETCH, 5'b10000, 3'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'b0);
        push(DECODE, 5'b0, 3'b0, 1'b1, 1'b0, 1'b0, 1'b0, OP_STORE);
        push(EXEC, 5'b0, 3'b0, 1'b1, 1'b0, 1'b0, 1'b0, OP_STORE);
        push(MEM, 5'b00001, 3'b0, 1'b1, 1'b0, 1'b0, 1'b0, OP_STORE);
        play();
        rst = 1'b0;
        #1;
        check_reset("reset_mem");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
